// File: rtl/script_pkg.sv
// Shared script-engine definitions: opcode values, error codes, sequencer states and
// the opcode -> minimum stack depth table used by the sequencer, ALU and loader.
package script_pkg;

  localparam logic [7:0] OP_NOP         = 8'h61;
  localparam logic [7:0] OP_VERIFY      = 8'h69;
  localparam logic [7:0] OP_DUP         = 8'h76;
  localparam logic [7:0] OP_EQUAL       = 8'h87;
  localparam logic [7:0] OP_EQUALVERIFY = 8'h88;
  localparam logic [7:0] OP_ADD         = 8'h93;
  localparam logic [7:0] OP_HASH160     = 8'ha9;
  localparam logic [7:0] OP_CHECKSIG    = 8'hac;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_UNDERFLOW  = 3'd1,
    ERR_ALU        = 3'd2,
    ERR_TIMEOUT    = 3'd3,
    ERR_EVAL_FALSE = 3'd4,
    ERR_BAD_OPCODE = 3'd5
  } err_code_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_EVAL,
    S_PASS,
    S_FAIL
  } seq_state_e;

  // Returns {known, min_depth[1:0]}; unknown opcodes return all zeros.
  function automatic logic [2:0] op_min_depth(input logic [7:0] opcode);
    case (opcode)
      OP_NOP:                              return 3'b1_00;
      OP_DUP, OP_HASH160, OP_VERIFY:       return 3'b1_01;
      OP_EQUAL, OP_EQUALVERIFY, OP_ADD,
      OP_CHECKSIG:                         return 3'b1_10;
      default:                             return 3'b0_00;
    endcase
  endfunction

endpackage

// File: rtl/script_op_decode.sv
// Combinational opcode classifier: whether the opcode is supported and how many
// stack entries it needs before it may be issued.
module script_op_decode
  import script_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       known,
  output logic [1:0] min_depth
);

  assign {known, min_depth} = op_min_depth(opcode);

endmodule

// File: rtl/script_exec_sequencer.sv
// Script execution sequencer: fetches opcodes, checks stack depth, issues them to the
// script ALU and ends in sticky PASS/FAIL. Define SCRIPT_TIMEOUT_EN for the ALU watchdog.
module script_exec_sequencer
  import script_pkg::*;
#(
  parameter int STACK_DEPTH = 20,
  parameter int OP_DEPTH    = 32,
  parameter int ALU_TIMEOUT = 1024,
  localparam int OPW = $clog2(OP_DEPTH),
  localparam int SDW = $clog2(STACK_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [OPW:0]   op_count,
  output logic [OPW-1:0] op_rd_addr,
  input  logic [7:0]     op_rd_data,
  input  logic [SDW-1:0] stk_depth,
  input  logic           stk_top_true,
  output logic [7:0]     alu_opcode,
  output logic           alu_valid,
  input  logic           alu_ready,
  input  logic           alu_done,
  input  logic           alu_error,
  output logic           busy,
  output logic           script_success,
  output logic           script_error,
  output logic [2:0]     err_code
);

  seq_state_e     state_q, state_d;
  err_code_e      err_q, err_d;
  logic [OPW-1:0] pc_q;
  logic [OPW:0]   n_q;
  logic [7:0]     opcode_q;
  logic           dec_known;
  logic [1:0]     dec_min;
  logic           timed_out;
  logic           last_op;

  script_op_decode u_decode (
    .opcode    (op_rd_data),
    .known     (dec_known),
    .min_depth (dec_min)
  );

`ifdef SCRIPT_TIMEOUT_EN
  localparam int TW = $clog2(ALU_TIMEOUT + 1);
  logic [TW-1:0] tmr_q;

  // Restarts on every state change, so ISSUE and WAIT each get a full budget.
  always_ff @(posedge clk) begin
    if (rst)                                  tmr_q <= '0;
    else if (state_d != state_q)              tmr_q <= '0;
    else if (state_q inside {S_ISSUE, S_WAIT}) tmr_q <= tmr_q + TW'(1);
  end

  assign timed_out = (state_q inside {S_ISSUE, S_WAIT}) && (tmr_q == TW'(ALU_TIMEOUT - 1));
`else
  // No watchdog in this build; ISSUE/WAIT may stall for as long as the ALU does.
  assign timed_out = 1'b0 && (ALU_TIMEOUT > 0);
`endif

  assign busy           = !(state_q inside {S_IDLE, S_PASS, S_FAIL});
  assign alu_valid      = (state_q == S_ISSUE);
  assign alu_opcode     = opcode_q;
  assign op_rd_addr     = pc_q;
  assign script_success = (state_q == S_PASS);
  assign script_error   = (state_q == S_FAIL);
  assign err_code       = err_q;
  assign last_op        = ({1'b0, pc_q} == (n_q - {{OPW{1'b0}}, 1'b1}));

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start) begin
          err_d   = ERR_NONE;
          state_d = (op_count == '0) ? S_EVAL : S_FETCH;
        end
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (!dec_known) begin
          state_d = S_FAIL;
          err_d   = ERR_BAD_OPCODE;
        end else if (stk_depth < SDW'(dec_min)) begin
          state_d = S_FAIL;
          err_d   = ERR_UNDERFLOW;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (alu_ready) begin
          state_d = S_WAIT;
        end else if (timed_out) begin
          state_d = S_FAIL;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_WAIT: begin
        if (alu_error) begin
          state_d = S_FAIL;
          err_d   = ERR_ALU;
        end else if (alu_done) begin
          state_d = S_NEXT;
        end else if (timed_out) begin
          state_d = S_FAIL;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_NEXT:  state_d = last_op ? S_EVAL : S_FETCH;
      S_EVAL: begin
        if ((stk_depth != '0) && stk_top_true) begin
          state_d = S_PASS;
        end else begin
          state_d = S_FAIL;
          err_d   = ERR_EVAL_FALSE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      err_q    <= ERR_NONE;
      pc_q     <= '0;
      n_q      <= '0;
      opcode_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (!busy && start) begin
        pc_q <= '0;
        n_q  <= op_count;
      end
      if (state_q == S_DECODE) opcode_q <= op_rd_data;
      if ((state_q == S_NEXT) && (state_d == S_FETCH)) pc_q <= pc_q + {{(OPW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_script_exec_sequencer.sv
// Directed bench for script_exec_sequencer: opcode buffer and ALU models, expected
// opcodes and final results queued at stimulus time and compared as the DUT produces them.
module tb_script_exec_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] op_count = '0;
  logic [4:0] op_rd_addr;
  logic [7:0] op_rd_data;
  logic [4:0] stk_depth = '0;
  logic       stk_top_true = 1'b0;
  logic [7:0] alu_opcode;
  logic       alu_valid;
  logic       alu_ready = 1'b1;
  logic       alu_done = 1'b0;
  logic       alu_error = 1'b0;
  logic       busy;
  logic       script_success;
  logic       script_error;
  logic [2:0] err_code;

  logic [7:0] mem [0:31];
  logic [7:0] exp_ops [$];
  logic [7:0] obs_ops [$];
  logic [3:0] res_q [$];
  logic       done_en = 1'b1;
  int         err_idx = -1;
  int         hs_cnt = 0;
  int         valid_cnt = 0;
  int         served = 0;
  int         checks = 0;
  int         errors = 0;
  int         last_cyc = 0;

  script_exec_sequencer #(
    .STACK_DEPTH (20),
    .OP_DEPTH    (32),
    .ALU_TIMEOUT (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .op_count       (op_count),
    .op_rd_addr     (op_rd_addr),
    .op_rd_data     (op_rd_data),
    .stk_depth      (stk_depth),
    .stk_top_true   (stk_top_true),
    .alu_opcode     (alu_opcode),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_done       (alu_done),
    .alu_error      (alu_error),
    .busy           (busy),
    .script_success (script_success),
    .script_error   (script_error),
    .err_code       (err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) op_rd_data <= mem[op_rd_addr];

  // ALU model: log each accepted opcode at the handshake edge.
  always @(posedge clk) begin
    if (!rst && alu_valid) valid_cnt++;
    if (!rst && alu_valid && alu_ready) begin
      obs_ops.push_back(alu_opcode);
      hs_cnt++;
    end
  end

  // Completion arrives exactly one cycle after the accept; error rides along with done.
  always @(negedge clk) begin
    alu_done  = 1'b0;
    alu_error = 1'b0;
    if (served != hs_cnt) begin
      served = hs_cnt;
      if (done_en) begin
        alu_done  = 1'b1;
        alu_error = ((hs_cnt - 1) == err_idx);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_script(input int n);
    op_count = 6'(n);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int cyc);
    cyc = 1;
    while (!(script_success || script_error) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic finish_check(input int base, input int exp_hs, input string tag);
    int         cyc;
    logic [3:0] exp_res;
    wait_end(300, cyc);
    last_cyc = cyc;
    chk({tag, "_end_reached"}, script_success || script_error, 1'b1);
    exp_res = (res_q.size() != 0) ? res_q.pop_front() : 4'hf;
    chk({tag, "_success"}, script_success, exp_res[3]);
    chk({tag, "_error"}, script_error, !exp_res[3]);
    chk({tag, "_err_code"}, err_code, exp_res[2:0]);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_handshakes"}, hs_cnt - base, exp_hs);
    for (int k = 0; k < exp_hs; k++) begin
      if (base + k < obs_ops.size() && base + k < exp_ops.size())
        chk({tag, "_opcode"}, obs_ops[base + k], exp_ops[base + k]);
    end
  endtask

  task automatic run(input int n, input int depth, input logic top, input logic exp_ok,
                     input int exp_err, input int exp_hs, input string tag);
    int base;
    base         = hs_cnt;
    stk_depth    = 5'(depth);
    stk_top_true = top;
    for (int k = 0; k < exp_hs; k++) exp_ops.push_back(mem[k]);
    res_q.push_back({exp_ok, 3'(exp_err)});
    start_script(n);
    finish_check(base, exp_hs, tag);
  endtask

  initial begin
    int base;
    int vbase;
    int cyc;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", busy, 1'b0);
    chk("reset_success", script_success, 1'b0);
    chk("reset_error", script_error, 1'b0);
    chk("reset_err_code", err_code, 3'd0);
    chk("reset_alu_valid", alu_valid, 1'b0);
    chk("reset_alu_opcode", alu_opcode, 8'h00);
    chk("reset_rd_addr", op_rd_addr, 5'd0);

    // P2PKH-like: 4 ops at 5 cycles each plus EVAL
    mem[0] = 8'h76; mem[1] = 8'ha9; mem[2] = 8'h88; mem[3] = 8'hac;
    run(4, 2, 1'b1, 1'b1, 0, 4, "p2pkh");
    chk("p2pkh_latency", last_cyc, 22);

    // Underflow: EQUAL needs two entries
    mem[0] = 8'h87;
    vbase = valid_cnt;
    run(1, 1, 1'b1, 1'b0, 1, 0, "underflow");
    chk("underflow_valid_cycles", valid_cnt - vbase, 0);

    // ALU error together with done on VERIFY
    mem[0] = 8'h61; mem[1] = 8'h69;
    err_idx = hs_cnt + 1;
    run(2, 1, 1'b1, 1'b0, 2, 2, "alu_err");
    err_idx = -1;

    // Unknown opcode at pc 1
    mem[0] = 8'h61; mem[1] = 8'hff;
    run(2, 2, 1'b1, 1'b0, 5, 1, "bad_opcode");

    // Empty script: outcome decided by EVAL alone
    run(0, 0, 1'b0, 1'b0, 4, 0, "empty_false");
    run(0, 1, 1'b1, 1'b1, 0, 0, "empty_true");

    // Ops complete but top of stack false
    mem[0] = 8'h61;
    run(1, 1, 1'b0, 1'b0, 4, 1, "eval_false");

    // Backpressure: ready low for 7 ISSUE cycles, plus a start pulse that must be ignored
    mem[0] = 8'h61;
    stk_depth = 5'd1; stk_top_true = 1'b1; alu_ready = 1'b0;
    base = hs_cnt;
    exp_ops.push_back(8'h61);
    res_q.push_back({1'b1, 3'd0});
    start_script(1);
    cyc = 0;
    while (!alu_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_valid_seen", alu_valid, 1'b1);
    chk("bp_opcode_1", alu_opcode, 8'h61);
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk("bp_valid_held", alu_valid, 1'b1);
      chk("bp_opcode_held", alu_opcode, 8'h61);
      if (i == 3) begin
        start    = 1'b1;
        op_count = 6'd2;
      end
      if (i == 8) alu_ready = 1'b1;
    end
    chk("bp_no_accept_yet", hs_cnt - base, 0);
    finish_check(base, 1, "backpressure");

    // Reset in the middle of WAIT, then a clean restart from pc 0
    mem[0] = 8'h61; mem[1] = 8'h61;
    stk_depth = 5'd1; stk_top_true = 1'b1; done_en = 1'b0;
    base = hs_cnt;
    exp_ops.push_back(8'h61);
    start_script(2);
    cyc = 0;
    while (hs_cnt == base && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_first_accept", hs_cnt - base, 1);
    repeat (2) @(negedge clk);
    chk("rst_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy_after", busy, 1'b0);
    chk("rst_valid_after", alu_valid, 1'b0);
    chk("rst_rd_addr_after", op_rd_addr, 5'd0);
    chk("rst_err_after", err_code, 3'd0);
    chk("rst_flags_after", {script_success, script_error}, 2'b00);
    if (obs_ops.size() > base) chk("rst_first_opcode", obs_ops[base], exp_ops[base]);
    done_en = 1'b1;
    run(2, 1, 1'b1, 1'b1, 0, 2, "rst_restart");

`ifdef SCRIPT_TIMEOUT_EN
    mem[0] = 8'h61;
    done_en = 1'b0;
    run(1, 1, 1'b1, 1'b0, 3, 1, "timeout");
    done_en = 1'b1;
`endif

    chk("scoreboard_drained", res_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
